// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM states, operation
// encodings and the digit-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count N = width/digit digits; never less than one bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from one-bit full-adder cells.
// Also exposes the carry into the top cell so the caller can form signed
// overflow from the final digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Processes DIGIT bits per clock through a
// single digit_adder slice with a registered carry, finishing a WIDTH-bit
// add (a+b+cin) or subtract (a-b) in WIDTH/DIGIT RUN cycles.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_param
    $error("serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d), 1 <= DIGIT <= WIDTH",
           WIDTH, DIGIT);
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == RUN);
  // DONE lasts exactly one cycle, so the state itself is the done pulse.
  assign done   = (state == DONE);
  assign accept = ready & start;
  assign last   = (state == RUN) && (cnt == LAST_CNT);

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x        (a_sh[DIGIT-1:0]),
    .y        (b_sh[DIGIT-1:0]),
    .ci       (carry),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_cmsb)
  );

  // New digits enter the result from the MSB side; with a single digit the
  // slice output is the whole result.
  if (N == 1) begin : g_one_digit
    assign res_next = slice_s;
  end else begin : g_multi_digit
    assign res_next = {slice_s, res_sh[WIDTH-1:DIGIT]};
  end

  // Next-state logic: start only matters while ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand/result shift registers, carry, digit counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= (op == OP_SUB) ? ~b : b;
      carry  <= (op == OP_SUB) ? 1'b1 : cin;
      res_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_next;
      carry  <= slice_co;
      if (last) begin
        cnt  <= '0;
        sum  <= res_next;
        cout <= slice_co;
        ovf  <= slice_co ^ slice_cmsb;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 16/4, 16/16)
// driven by directed steps and random operations, compared against a plain
// arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op  = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        cin = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0, start16w = 1'b0;

  logic        ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        ready16, busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        ready16w, busy16w, done16w, cout16w, ovf16w;
  logic [15:0] sum16w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16w (
    .clk(clk), .rst(rst), .start(start16w), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready16w), .busy(busy16w), .done(done16w), .sum(sum16w), .cout(cout16w), .ovf(ovf16w)
  );

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  function automatic int digits_of(input int sel);
    return (sel == 0) ? 8 : ((sel == 1) ? 4 : 1);
  endfunction

  // Reference: the arithmetic result of a+b+cin or a-b at width w.
  function automatic void model(input int w, input logic op_i, input logic [15:0] a_i,
                                input logic [15:0] b_i, input logic cin_i,
                                output logic [15:0] s, output logic c, output logic v);
    int unsigned m, av, bv, r;
    logic sa, sb, ss;
    m  = (32'd1 << w) - 1;
    av = 32'(a_i) & m;
    bv = 32'(b_i) & m;
    if (op_i == 1'b0) begin
      r = av + bv + 32'(cin_i);
      c = ((r >> w) & 1) != 0;
    end else begin
      r = av - bv;
      c = (av >= bv);
    end
    s  = 16'(r & m);
    sa = ((av >> (w - 1)) & 1) != 0;
    sb = ((bv >> (w - 1)) & 1) != 0;
    ss = ((r  >> (w - 1)) & 1) != 0;
    if (op_i == 1'b0) v = (sa == sb) && (ss != sa);
    else              v = (sa != sb) && (ss != sa);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start8   = v;
      1:       start16  = v;
      default: start16w = v;
    endcase
  endtask

  task automatic sample(input int sel, output logic d, output logic r, output logic bz,
                        output logic [15:0] s, output logic c, output logic v);
    case (sel)
      0:       begin d = done8;   r = ready8;   bz = busy8;   s = {8'h00, sum8}; c = cout8;   v = ovf8;   end
      1:       begin d = done16;  r = ready16;  bz = busy16;  s = sum16;         c = cout16;  v = ovf16;  end
      default: begin d = done16w; r = ready16w; bz = busy16w; s = sum16w;        c = cout16w; v = ovf16w; end
    endcase
  endtask

  task automatic chk_reset_state(input int sel, input string tag);
    logic d, r, bz, c, v;
    logic [15:0] s;
    sample(sel, d, r, bz, s, c, v);
    chk({tag, "_ready"}, 32'(r),  32'd1);
    chk({tag, "_busy"},  32'(bz), 32'd0);
    chk({tag, "_done"},  32'(d),  32'd0);
    chk({tag, "_sum"},   32'(s),  32'd0);
    chk({tag, "_cout"},  32'(c),  32'd0);
    chk({tag, "_ovf"},   32'(v),  32'd0);
  endtask

  // Launch one operation from the current cycle (called just after a rising
  // edge) and wait for its done. mode 1: pulse start with other operands
  // mid-RUN; mode 2: reset mid-RUN and check the abort.
  task automatic run(input int sel, input logic op_i, input logic [15:0] a_i,
                     input logic [15:0] b_i, input logic cin_i,
                     input logic [15:0] es, input logic ec, input logic ev,
                     input int mode, input string tag);
    logic d, r, bz, c, v, extra;
    logic [15:0] s;
    int lat;
    op = op_i; a = a_i; b = b_i; cin = cin_i;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    lat = 0;
    for (int k = 1; k <= digits_of(sel) + 4 && lat == 0; k++) begin
      if (k == 1) begin
        sample(sel, d, r, bz, s, c, v);
        chk({tag, "_busy_run"},  32'(bz), 32'd1);
        chk({tag, "_ready_run"}, 32'(r),  32'd0);
      end
      if (mode == 1 && k == 4) begin
        op = ~op_i; a = ~a_i; b = ~b_i; cin = ~cin_i;
        set_start(sel, 1'b1);
      end
      if (mode == 2 && k == 5) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state(sel, {tag, "_abort"});
        extra = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          sample(sel, d, r, bz, s, c, v);
          if (d) extra = 1'b1;
        end
        chk({tag, "_abort_no_done"}, 32'(extra), 32'd0);
        return;
      end
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      sample(sel, d, r, bz, s, c, v);
      if (d) lat = k;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(digits_of(sel)));
    chk({tag, "_sum"},     32'(s),   32'(es));
    chk({tag, "_cout"},    32'(c),   32'(ec));
    chk({tag, "_ovf"},     32'(v),   32'(ev));
    chk({tag, "_ready"},   32'(r),   32'd1);
  endtask

  // One cycle with no start: done must have dropped and the unit be idle.
  task automatic idle_check(input int sel, input string tag);
    logic d, r, bz, c, v;
    logic [15:0] s;
    @(posedge clk); #1;
    sample(sel, d, r, bz, s, c, v);
    chk({tag, "_done_low"}, 32'(d),  32'd0);
    chk({tag, "_idle"},     32'({r, bz}), 32'b10);
  endtask

  task automatic run_model(input int sel, input logic op_i, input logic [15:0] a_i,
                           input logic [15:0] b_i, input logic cin_i, input string tag);
    logic [15:0] es;
    logic ec, ev;
    model(width_of(sel), op_i, a_i, b_i, cin_i, es, ec, ev);
    run(sel, op_i, a_i, b_i, cin_i, es, ec, ev, 0, tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) chk_reset_state(s, "reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit, one bit per cycle
    run(0, 1'b0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1, 0, "add5a3c");
    idle_check(0, "add5a3c");
    run(0, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 0, "addff01c");
    run(0, 1'b1, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b0, 1'b0, 0, "sub1020_b2b");
    idle_check(0, "sub1020");
    run(0, 1'b1, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1, 0, "sub8001_cin");
    idle_check(0, "sub8001");
    run(0, 1'b0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 1, "ignored_start");
    idle_check(0, "ignored_start1");
    idle_check(0, "ignored_start2");
    run(0, 1'b0, 16'h0055, 16'h000F, 1'b0, 16'h0000, 1'b0, 1'b0, 2, "rst_mid_run");
    run(0, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, "add0101");
    idle_check(0, "add0101");

    // 16-bit, four bits per cycle, then whole word per cycle
    run(1, 1'b0, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "d4_add");
    idle_check(1, "d4_add");
    run(2, 1'b0, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "d16_add");
    idle_check(2, "d16_add");
    run(2, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0, "d16_sub_b2b0");
    run(2, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, "d16_sub_b2b1");
    idle_check(2, "d16_sub");

    // Random operations, mixing back-to-back and idle gaps
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 12; i++) begin
        run_model(s, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), $sformatf("rand_s%0d_%0d", s, i));
        if ($urandom_range(0, 1) == 1) idle_check(s, $sformatf("rand_s%0d_%0d", s, i));
      end
      idle_check(s, $sformatf("rand_s%0d_end", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
